// File: rtl/can_destuff_crc_if.sv
// Bus-side bundle for the CAN destuffer/CRC block: bit-timing and capture-stage
// controls in, accepted-bit stream and CRC status out.
interface can_destuff_crc_if #(
  parameter int CNT_W = 8
);
  logic             sample_valid;
  logic             rx_bit;
  logic             stuffing;
  logic             run_crc;
  logic             clear;
  logic             bit_en;
  logic             bit_out;
  logic             stuff_err;
  logic             crc_valid;
  logic             crc_ok;
  logic [14:0]      crc;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output sample_valid, rx_bit, stuffing, run_crc, clear,
    input  bit_en, bit_out, stuff_err, crc_valid, crc_ok, crc, bit_cnt
  );

  modport slave (
    input  sample_valid, rx_bit, stuffing, run_crc, clear,
    output bit_en, bit_out, stuff_err, crc_valid, crc_ok, crc, bit_cnt
  );
endinterface

// File: rtl/can_destuff_crc.sv
// CAN receive path: removes stuff bits, flags stuff-rule violations, counts
// accepted bits and runs the CRC-15 check over the accepted stream.
module can_destuff_crc #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter int          CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  can_destuff_crc_if.slave   bus
);

  logic             last_bit_q;
  logic [2:0]       run_len_q;
  logic             fresh_q;
  logic [14:0]      crc_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             stuff_err_q;
  logic             run_crc_d_q;
  logic             crc_ok_q;
  logic             crc_valid_q;
  logic             bit_en_q;
  logic             bit_out_q;

  logic        sample;
  logic        at_limit;
  logic        same;
  logic        accept;
  logic        violation;
  logic        crc_en;
  logic        check;
  logic        fb;
  logic [2:0]  run_len_d;
  logic [14:0] crc_shift;
  logic [14:0] crc_d;

  // A latched stuff error blocks every further sample until clear/reset.
  always_comb begin
    sample    = bus.sample_valid && !stuff_err_q;
    same      = (bus.rx_bit == last_bit_q);
    at_limit  = bus.stuffing && (run_len_q == 3'd5);
    accept    = sample && !at_limit;
    violation = sample && at_limit && same;
    // The idle recessive level must not count toward the first run of a frame.
    if (fresh_q || !same) begin
      run_len_d = 3'd1;
    end else if (run_len_q == 3'd5) begin
      run_len_d = 3'd5;
    end else begin
      run_len_d = run_len_q + 3'd1;
    end
    // The falling-edge cycle still feeds its own bit before the check.
    crc_en = accept && (bus.run_crc || run_crc_d_q);
    check  = run_crc_d_q && !bus.run_crc;
    fb     = bus.rx_bit ^ crc_q[14];
    crc_d  = crc_en ? crc_shift : crc_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_crc
      if (gi == 0) begin : g_lsb
        assign crc_shift[gi] = fb & CRC_POLY[gi];
      end else begin : g_upper
        assign crc_shift[gi] = crc_q[gi-1] ^ (fb & CRC_POLY[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_bit_q  <= 1'b1;
      run_len_q   <= 3'd1;
      fresh_q     <= 1'b1;
      crc_q       <= '0;
      bit_cnt_q   <= '0;
      stuff_err_q <= 1'b0;
      run_crc_d_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_valid_q <= 1'b0;
      bit_en_q    <= 1'b0;
      bit_out_q   <= 1'b1;
    end else begin
      run_crc_d_q <= bus.run_crc;
      if (bus.clear) begin
        last_bit_q  <= 1'b1;
        run_len_q   <= 3'd1;
        fresh_q     <= 1'b1;
        crc_q       <= '0;
        bit_cnt_q   <= '0;
        stuff_err_q <= 1'b0;
        crc_ok_q    <= 1'b0;
        crc_valid_q <= 1'b0;
        bit_en_q    <= 1'b0;
      end else begin
        bit_en_q    <= accept;
        crc_valid_q <= check;
        crc_q       <= crc_d;
        if (accept) begin
          bit_out_q <= bus.rx_bit;
        end
        if (check) begin
          crc_ok_q <= (crc_d == 15'd0);
        end
        if (sample) begin
          last_bit_q <= bus.rx_bit;
          run_len_q  <= run_len_d;
          fresh_q    <= 1'b0;
        end
        if (violation) begin
          stuff_err_q <= 1'b1;
        end
        if (accept && (bit_cnt_q != '1)) begin
          bit_cnt_q <= bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign bus.bit_en    = bit_en_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.stuff_err = stuff_err_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc       = crc_q;
  assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_can_destuff_crc.sv
// Self-checking bench for can_destuff_crc: table of stuffing vectors, a CAN
// frame CRC round trip, clear/reset corner cases and counter saturation.
module tb_can_destuff_crc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_destuff_crc_if #(.CNT_W(8)) bus ();
  can_destuff_crc_if #(.CNT_W(3)) bus3 ();

  can_destuff_crc #(.CRC_POLY(15'h4599), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  can_destuff_crc #(.CRC_POLY(15'h4599), .CNT_W(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  typedef struct {
    logic        stuffing;
    logic [15:0] bits;
    int          n;
    logic [15:0] out;
    int          out_n;
    logic        err;
    int          cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Scoreboard: every accepted bit must match the oldest expected bit.
  always @(negedge clk) begin
    if (rst && bus.bit_en) begin
      if (exp_q.size() == 0) begin
        check("bit_en_unexpected", {31'd0, bus.bit_en}, 32'd0);
      end else begin
        check("bit_out", {31'd0, bus.bit_out}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic b, input logic drop);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.rx_bit       = b;
    if (drop) bus.run_crc = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [14:0] crc15(input logic q[$]);
    logic [14:0] c;
    logic        nxt;
    c = '0;
    foreach (q[i]) begin
      nxt = q[i] ^ c[14];
      c   = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  task automatic send_frame(input int flip, input logic want_ok);
    logic        f[$];
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [7:0]  data;
    logic [14:0] c;
    int          run;
    logic        last;
    logic        b;
    logic        got;
    logic        ok;
    logic [14:0] crc_seen;
    id   = 11'h123;
    dlc  = 4'd1;
    data = 8'h55;
    f.push_back(1'b0);
    for (int i = 10; i >= 0; i--) f.push_back(id[i]);
    for (int i = 0; i < 3; i++) f.push_back(1'b0);
    for (int i = 3; i >= 0; i--) f.push_back(dlc[i]);
    for (int i = 7; i >= 0; i--) f.push_back(data[i]);
    c = crc15(f);
    for (int i = 14; i >= 0; i--) f.push_back(c[i]);
    do_clear();
    bus.stuffing = 1'b1;
    bus.run_crc  = 1'b1;
    run  = 0;
    last = 1'b1;
    for (int i = 0; i < f.size(); i++) begin
      b = f[i] ^ (i == flip);
      if (run == 5) begin
        drive(~last, 1'b0);
        last = ~last;
        run  = 1;
      end
      if (b == last) run++;
      else begin
        run  = 1;
        last = b;
      end
      exp_q.push_back(b);
      drive(b, i == f.size() - 1);
    end
    got      = 1'b0;
    ok       = 1'b0;
    crc_seen = '0;
    for (int k = 0; k < 6; k++) begin
      if (bus.crc_valid) begin
        got      = 1'b1;
        ok       = bus.crc_ok;
        crc_seen = bus.crc;
        break;
      end
      @(negedge clk);
    end
    check("crc_valid_seen", {31'd0, got}, 32'd1);
    check("crc_ok", {31'd0, ok}, {31'd0, want_ok});
    if (want_ok) check("crc_zero", {17'd0, crc_seen}, 32'd0);
    check("frame_bit_cnt", {24'd0, bus.bit_cnt}, f.size());
    check("frame_stuff_err", {31'd0, bus.stuff_err}, 32'd0);
    if (got) begin
      @(negedge clk);
      check("crc_valid_pulse", {31'd0, bus.crc_valid}, 32'd0);
    end
    check("frame_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sample_valid  = 1'b0;
    bus.rx_bit        = 1'b1;
    bus.stuffing      = 1'b0;
    bus.run_crc       = 1'b0;
    bus.clear         = 1'b0;
    bus3.sample_valid = 1'b0;
    bus3.rx_bit       = 1'b1;
    bus3.stuffing     = 1'b0;
    bus3.run_crc      = 1'b0;
    bus3.clear        = 1'b0;

    //               stuffing bits              n   out                 out_n err  cnt
    vecs[0] = '{1'b1, 16'b0000010,          7,  16'b000000,         6,  1'b0, 6};
    vecs[1] = '{1'b1, 16'b11111111,         8,  16'b11111,          5,  1'b1, 5};
    vecs[2] = '{1'b0, 16'b1111111,          7,  16'b1111111,        7,  1'b0, 7};
    vecs[3] = '{1'b1, 16'b0101010101,       10, 16'b0101010101,     10, 1'b0, 10};
    vecs[4] = '{1'b1, 16'b000000,           6,  16'b00000,          5,  1'b1, 5};
    vecs[5] = '{1'b1, 16'b1111101111,       10, 16'b111111111,      9,  1'b0, 9};

    #2 rst = 1'b0;
    #1;
    check("reset_state",
          {bus.bit_en, bus.bit_out, bus.stuff_err, bus.crc_valid, bus.crc_ok, bus.crc, bus.bit_cnt},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 8'd0});
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[v]) begin
      do_clear();
      bus.stuffing = vecs[v].stuffing;
      for (int j = 0; j < vecs[v].out_n; j++) exp_q.push_back(vecs[v].out[vecs[v].out_n-1-j]);
      for (int i = 0; i < vecs[v].n; i++) drive(vecs[v].bits[vecs[v].n-1-i], 1'b0);
      repeat (2) @(negedge clk);
      $display("vector %0d: bit_cnt=%0d stuff_err=%0b pending=%0d", v, bus.bit_cnt, bus.stuff_err, exp_q.size());
      check("vec_pending", exp_q.size(), 32'd0);
      check("vec_bit_cnt", {24'd0, bus.bit_cnt}, vecs[v].cnt);
      check("vec_stuff_err", {31'd0, bus.stuff_err}, {31'd0, vecs[v].err});
    end

    send_frame(-1, 1'b1);
    $display("frame good: crc_ok=%0b crc=%0h", bus.crc_ok, bus.crc);
    send_frame(40, 1'b0);
    $display("frame flipped: crc_ok=%0b crc=%0h", bus.crc_ok, bus.crc);

    // clear coinciding with a sample discards it
    do_clear();
    bus.stuffing = 1'b0;
    bus.run_crc  = 1'b1;
    exp_q.push_back(1'b1); drive(1'b1, 1'b0);
    exp_q.push_back(1'b0); drive(1'b0, 1'b0);
    exp_q.push_back(1'b1); drive(1'b1, 1'b0);
    check("pre_clear_cnt", {24'd0, bus.bit_cnt}, 32'd3);
    @(negedge clk);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.rx_bit       = 1'b1;
    @(negedge clk);
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.run_crc      = 1'b0;
    $display("clear+sample: bit_en=%0b bit_cnt=%0d crc=%0h", bus.bit_en, bus.bit_cnt, bus.crc);
    check("clear_bit_en", {31'd0, bus.bit_en}, 32'd0);
    check("clear_bit_cnt", {24'd0, bus.bit_cnt}, 32'd0);
    check("clear_crc", {17'd0, bus.crc}, 32'd0);

    // asynchronous reset mid-frame
    do_clear();
    bus.stuffing = 1'b1;
    bus.run_crc  = 1'b1;
    exp_q.push_back(1'b1); drive(1'b1, 1'b0);
    exp_q.push_back(1'b1); drive(1'b1, 1'b0);
    exp_q.push_back(1'b0); drive(1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    $display("mid-frame reset: crc=%0h bit_cnt=%0d bit_out=%0b", bus.crc, bus.bit_cnt, bus.bit_out);
    check("midframe_reset",
          {bus.bit_en, bus.bit_out, bus.stuff_err, bus.crc_valid, bus.crc_ok, bus.crc, bus.bit_cnt},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 8'd0});
    bus.run_crc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();

    // fresh start after reset: six 1s with stuffing still yields five accepted bits
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    $display("post-reset run: bit_cnt=%0d stuff_err=%0b", bus.bit_cnt, bus.stuff_err);
    check("post_reset_cnt", {24'd0, bus.bit_cnt}, 32'd5);
    check("post_reset_err", {31'd0, bus.stuff_err}, 32'd1);
    check("post_reset_pending", exp_q.size(), 32'd0);

    // narrow counter saturates
    @(negedge clk);
    bus3.clear = 1'b1;
    @(negedge clk);
    bus3.clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus3.sample_valid = 1'b1;
      bus3.rx_bit       = i[0];
      @(negedge clk);
      bus3.sample_valid = 1'b0;
      if (i == 6) check("cnt3_at7", {29'd0, bus3.bit_cnt}, 32'd7);
    end
    repeat (2) @(negedge clk);
    $display("cnt_w3: bit_cnt=%0d", bus3.bit_cnt);
    check("cnt3_saturated", {29'd0, bus3.bit_cnt}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_destuff_crc.md
CAN_DESTUFF_CRC -- requirements
Module: can_destuff_crc

Interface
REQ-001 Parameter CRC_POLY, default 15'h4599, CAN CRC-15 generator polynomial without the x^15 term.
REQ-002 Parameter CNT_W, default 8, width of the accepted-bit counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 sample_valid  in  1  one-cycle strobe, one per bus bit time, from bit timing.
REQ-006 rx_bit  in  1  sampled bus level, valid only with sample_valid.
REQ-007 stuffing  in  1  level; 1 = destuffing active (driven by the packet capture stage).
REQ-008 run_crc  in  1  level; 1 = accepted bits feed the CRC register.
REQ-009 clear  in  1  synchronous per-frame restart (driven by capture-stage done).
REQ-010 bit_en  out  1  one-cycle strobe, one per accepted non-stuff bit; drives capture-stage en.
REQ-011 bit_out  out  1  accepted bit value, valid with bit_en.
REQ-012 stuff_err  out  1  sticky stuff-rule violation flag.
REQ-013 crc_valid  out  1  one-cycle strobe when a CRC check completes.
REQ-014 crc_ok  out  1  CRC remainder was zero; valid with crc_valid, held until next check or clear.
REQ-015 crc  out  15  current CRC shift register.
REQ-016 bit_cnt  out  CNT_W  accepted bits since clear, saturating at all-ones.

Function
REQ-017 State: last_bit (1), run_len (3 bits, 1..5), crc (15), bit_cnt, stuff_err, run_crc_d (1-cycle delayed run_crc), crc_ok.
REQ-018 Latency: bit_en/bit_out are registered and assert exactly one cycle after the accepting sample_valid.
REQ-019 No sample_valid -> bit_en=0; no state other than run_crc_d changes.
REQ-020 stuffing=0: every sample is accepted; last_bit<=rx_bit; run_len<=1 if rx_bit!=last_bit, else min(run_len+1,5).
REQ-021 stuffing=1, run_len<5: sample accepted; run_len/last_bit updated as in REQ-020.
REQ-022 stuffing=1, run_len==5, rx_bit!=last_bit: stuff bit; dropped (no bit_en, no CRC, no bit_cnt); run_len<=1; last_bit<=rx_bit.
REQ-023 stuffing=1, run_len==5, rx_bit==last_bit: stuff_err<=1 next cycle; sample dropped.
REQ-024 While stuff_err=1: bit_en held 0; CRC and bit_cnt frozen; only clear or rst releases.
REQ-025 CRC update per accepted bit with run_crc=1: fb=rx_bit^crc[14]; crc<=({crc[13:0],1'b0}) ^ (fb ? CRC_POLY : 0), truncated to 15 bits.
REQ-026 Accepted bits with run_crc=0 leave crc unchanged.
REQ-027 Check: cycle where run_crc_d=1 and run_crc=0 -> next cycle crc_valid=1 for one cycle, crc_ok<=(crc==0), crc itself unchanged.
REQ-028 A bit accepted in the same cycle as the run_crc falling edge is included in the CRC before the check is evaluated.
REQ-029 bit_cnt increments per accepted bit; saturates at 2^CNT_W-1 without wrap.
REQ-030 clear=1: crc<=0, run_len<=1, last_bit<=1 (recessive), bit_cnt<=0, stuff_err<=0, crc_ok<=0, bit_en<=0, crc_valid<=0; overrides a coincident sample_valid (sample discarded).
REQ-031 run_len counting is independent of run_crc; a stuff bit counts as the first bit of the next run.

Reset
REQ-032 rst=0 forces immediately: bit_en=0, bit_out=1, stuff_err=0, crc_valid=0, crc_ok=0, crc=0, bit_cnt=0, run_len=1, last_bit=1, run_crc_d=0.
REQ-033 Reset asserted mid-frame discards all partial state; first sample after release is treated as a fresh frame start.
REQ-034 Outputs carry no glitches from the reset deassertion edge; first bit_en no earlier than one cycle after first post-reset sample_valid.

Verification
REQ-035 stuffing=1, bits 0,0,0,0,0,1(stuff),0 -> 6 bit_en strobes, bit_out 0,0,0,0,0,0; bit_cnt=6; stuff_err=0.
REQ-036 stuffing=1, six consecutive 1s after clear -> 5 bit_en, stuff_err=1 after sixth sample; further samples give no bit_en.
REQ-037 stuffing=0, seven 1s -> 7 bit_en, no stuff_err, bit_cnt=7.
REQ-038 run_crc=1, feed standard ID 0x123 data frame (DLC=1, data 0x55) plus its transmitted 15-bit CRC, then drop run_crc -> crc_valid pulse, crc_ok=1, crc=0; flip one CRC bit -> crc_ok=0.
REQ-039 clear and sample_valid same cycle -> no bit_en, bit_cnt=0, crc=0; rst pulse mid-frame -> all outputs at REQ-032 values within same cycle.
REQ-040 CNT_W=3, 9 accepted bits -> bit_cnt=7 holds, no wrap.
